// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the writeback stage:
//   XLEN          datapath width (matches the register file)
//   LB..LWU       RISC-V load funct3 encodings
//   wb_entry_t    buffered ALU result {rd, data}
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Small synchronous FIFO with asynchronous active-low reset.
// Ports:
//   clk, rst_n     clock / async active-low reset
//   push,push_data enqueue request; ignored while full (even with a pop)
//   pop, pop_data  dequeue request; pop_data shows the head entry
//   full, empty    status from registered state only
//   count          number of stored entries (0..DEPTH)
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module wb_fifo #(
    parameter int unsigned WIDTH = 69,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observable once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
// Writeback stage feeding the register file write port. Loads (always
// accepted) take priority; ALU results wait in a small FIFO and retire in
// order whenever no load is present. One registered write per cycle.
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//   lsu_valid/lsu_rd/lsu_funct3/lsu_addr_lo/lsu_rdata  load return
//   rf_we/rf_rd/rf_wdata            register file write port (registered)
//   wb_idle                         FIFO empty and no write in flight
// Optional: define WRITEBACK_STATS_EN to add stat_retired / stat_alu_stall.
// -----------------------------------------------------------------------------
module writeback_unit
    import wb_pkg::*;
#(
    parameter int unsigned XLEN           = wb_pkg::XLEN,
    parameter int unsigned ALU_FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [2:0]      lsu_funct3,
    input  logic [2:0]      lsu_addr_lo,
    input  logic [XLEN-1:0] lsu_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic            wb_idle
`ifdef WRITEBACK_STATS_EN
   ,output logic [31:0]     stat_retired,
    output logic [31:0]     stat_alu_stall
`endif
);

    // Byte/half/word are selected by shifting the aligned slot down to bit 0;
    // low offset bits below the access size drop out of the shift amount.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [2:0]      f3,
        input logic [2:0]      o,
        input logic [XLEN-1:0] raw
    );
        logic [XLEN-1:0] b_sh;
        logic [XLEN-1:0] h_sh;
        logic [XLEN-1:0] w_sh;
        logic [XLEN-1:0] res;
        b_sh = raw >> {o, 3'b000};
        h_sh = raw >> {o[2:1], 4'b0000};
        w_sh = raw >> {o[2], 5'b00000};
        case (f3)
            LB:      res = {{(XLEN-8){b_sh[7]}},   b_sh[7:0]};
            LBU:     res = {{(XLEN-8){1'b0}},      b_sh[7:0]};
            LH:      res = {{(XLEN-16){h_sh[15]}}, h_sh[15:0]};
            LHU:     res = {{(XLEN-16){1'b0}},     h_sh[15:0]};
            LW:      res = {{(XLEN-32){w_sh[31]}}, w_sh[31:0]};
            LWU:     res = {{(XLEN-32){1'b0}},     w_sh[31:0]};
            default: res = raw;  // LD and the unused 111 encoding
        endcase
        return res;
    endfunction

    localparam int unsigned CNT_W = $clog2(ALU_FIFO_DEPTH) + 1;

    wb_entry_t        push_entry;
    wb_entry_t        head_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_push;
    logic             fifo_pop;

    logic             sel_valid;
    logic [4:0]       sel_rd;
    logic [XLEN-1:0]  sel_data;
    logic             wr_next;

    assign push_entry = '{rd: alu_rd, data: alu_data};
    assign alu_ready  = !fifo_full;
    assign fifo_push  = alu_valid && alu_ready;
    assign fifo_pop   = !lsu_valid && !fifo_empty;

    wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (ALU_FIFO_DEPTH)
    ) u_alu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = head_entry.rd;
        sel_data  = head_entry.data;
        if (lsu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = lsu_rd;
            sel_data  = load_extract(lsu_funct3, lsu_addr_lo, lsu_rdata);
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
        end
    end

    // x0 entries are consumed but never written.
    assign wr_next = sel_valid && (sel_rd != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= wr_next;
            if (wr_next) begin
                rf_rd    <= sel_rd;
                rf_wdata <= sel_data;
            end
        end
    end

    assign wb_idle = (fifo_count == '0) && !rf_we;

`ifdef WRITEBACK_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_retired   <= '0;
            stat_alu_stall <= '0;
        end else begin
            if (wr_next)                 stat_retired   <= stat_retired + 32'd1;
            if (alu_valid && !alu_ready) stat_alu_stall <= stat_alu_stall + 32'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
    import wb_pkg::*;

    localparam int unsigned TXLEN  = 64;
    localparam int unsigned TDEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             alu_valid;
    logic             alu_ready;
    logic [4:0]       alu_rd;
    logic [TXLEN-1:0] alu_data;
    logic             lsu_valid;
    logic [4:0]       lsu_rd;
    logic [2:0]       lsu_funct3;
    logic [2:0]       lsu_addr_lo;
    logic [TXLEN-1:0] lsu_rdata;
    logic             rf_we;
    logic [4:0]       rf_rd;
    logic [TXLEN-1:0] rf_wdata;
    logic             wb_idle;
`ifdef WRITEBACK_STATS_EN
    logic [31:0]      stat_retired;
    logic [31:0]      stat_alu_stall;
`endif

    always #5 clk = ~clk;

    writeback_unit #(
        .XLEN           (TXLEN),
        .ALU_FIFO_DEPTH (TDEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .lsu_valid      (lsu_valid),
        .lsu_rd         (lsu_rd),
        .lsu_funct3     (lsu_funct3),
        .lsu_addr_lo    (lsu_addr_lo),
        .lsu_rdata      (lsu_rdata),
        .rf_we          (rf_we),
        .rf_rd          (rf_rd),
        .rf_wdata       (rf_wdata),
        .wb_idle        (wb_idle)
`ifdef WRITEBACK_STATS_EN
       ,.stat_retired   (stat_retired),
        .stat_alu_stall (stat_alu_stall)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: pending ALU results and the expected write port.
    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ref_t;
    ref_t        mq[$];
    logic        m_we;
    logic [4:0]  m_rd;
    logic [63:0] m_data;
    bit          m_known;
    bit          m_pushed;
    bit          auto_en;

    // Load extraction from access size/sign and natural alignment.
    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] o,
                                             input logic [63:0] raw);
        int unsigned n;
        bit          s;
        int unsigned off;
        logic [63:0] v;
        case (f3)
            3'd0: begin n = 1; s = 1; end
            3'd1: begin n = 2; s = 1; end
            3'd2: begin n = 4; s = 1; end
            3'd4: begin n = 1; s = 0; end
            3'd5: begin n = 2; s = 0; end
            3'd6: begin n = 4; s = 0; end
            default: begin n = 8; s = 0; end
        endcase
        off = (int'(o) / n) * n;
        v = raw >> (8 * off);
        if (n < 8) begin
            v = v & ((64'd1 << (8 * n)) - 64'd1);
            if (s && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_we     = 1'b0;
        m_rd     = '0;
        m_data   = '0;
        m_known  = 1'b1;
        m_pushed = 1'b0;
    endtask

    task automatic model_step();
        bit   ready;
        bit   have;
        ref_t e;
        ready = (mq.size() < TDEPTH);
        have  = 1'b0;
        if (lsu_valid) begin
            have   = 1'b1;
            e.rd   = lsu_rd;
            e.data = ref_load(lsu_funct3, lsu_addr_lo, lsu_rdata);
        end else if (mq.size() > 0) begin
            have = 1'b1;
            e    = mq.pop_front();
        end
        if (have && e.rd != 5'd0) begin
            m_we    = 1'b1;
            m_rd    = e.rd;
            m_data  = e.data;
            m_known = 1'b1;
        end else begin
            m_we = 1'b0;
            if (have) m_known = 1'b0;
        end
        m_pushed = alu_valid && ready;
        if (m_pushed) mq.push_back('{rd: alu_rd, data: alu_data});
    endtask

    task automatic auto_check();
        if (!auto_en) return;
        check("rf_we", rf_we, m_we);
        check("alu_ready", alu_ready, (mq.size() < TDEPTH));
        check("wb_idle", wb_idle, (mq.size() == 0) && !m_we);
        if (m_known) begin
            check("rf_rd", rf_rd, m_rd);
            check("rf_wdata", rf_wdata, m_data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        auto_check();
    endtask

    task automatic idle_inputs();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        lsu_valid   = 1'b0;
        lsu_rd      = '0;
        lsu_funct3  = '0;
        lsu_addr_lo = '0;
        lsu_rdata   = '0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [2:0]  o;
        logic [63:0] raw;
        logic [4:0]  rd;
        logic [63:0] exp;
    } ld_vec_t;
    ld_vec_t lv[12];

    initial begin
        int   pushed;
        int   writes;
        int   got[$];

        lv[0]  = '{LB,   3'd3, 64'h00000000_80000000, 5'd1,  64'hFFFFFFFF_FFFFFF80};
        lv[1]  = '{LBU,  3'd3, 64'h00000000_80000000, 5'd2,  64'h00000000_00000080};
        lv[2]  = '{LWU,  3'd4, 64'hDEADBEEF_00000000, 5'd3,  64'h00000000_DEADBEEF};
        lv[3]  = '{LW,   3'd5, 64'hDEADBEEF_00000000, 5'd4,  64'hFFFFFFFF_DEADBEEF};
        lv[4]  = '{LH,   3'd3, 64'h01234567_89ABCDEF, 5'd5,  64'hFFFFFFFF_FFFF89AB};
        lv[5]  = '{LHU,  3'd7, 64'h01234567_89ABCDEF, 5'd6,  64'h00000000_00000123};
        lv[6]  = '{LD,   3'd5, 64'h01234567_89ABCDEF, 5'd7,  64'h01234567_89ABCDEF};
        lv[7]  = '{3'b111, 3'd2, 64'h01234567_89ABCDEF, 5'd8, 64'h01234567_89ABCDEF};
        lv[8]  = '{LBU,  3'd0, 64'h01234567_89ABCDEF, 5'd9,  64'h00000000_000000EF};
        lv[9]  = '{LB,   3'd6, 64'h01234567_89ABCDEF, 5'd10, 64'h00000000_00000023};
        lv[10] = '{LB,   3'd1, 64'h01234567_89ABCDEF, 5'd11, 64'hFFFFFFFF_FFFFFFCD};
        lv[11] = '{LW,   3'd0, 64'h01234567_89ABCDEF, 5'd12, 64'hFFFFFFFF_89ABCDEF};

        idle_inputs();
        rst_n   = 1'b0;
        auto_en = 1'b0;
        model_reset();

        // Reset state
        #2;
        check("reset_rf_we", rf_we, 0);
        check("reset_rf_rd", rf_rd, 0);
        check("reset_rf_wdata", rf_wdata, 0);
        check("reset_wb_idle", wb_idle, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        auto_en = 1'b1;
        tick();
        check("post_reset_ready", alu_ready, 1);

        // Load extraction table
        for (int i = 0; i < 12; i++) begin
            lsu_valid   = 1'b1;
            lsu_funct3  = lv[i].f3;
            lsu_addr_lo = lv[i].o;
            lsu_rdata   = lv[i].raw;
            lsu_rd      = lv[i].rd;
            tick();
            lsu_valid = 1'b0;
            check($sformatf("ld%0d_we", i), rf_we, 1);
            check($sformatf("ld%0d_rd", i), rf_rd, lv[i].rd);
            check($sformatf("ld%0d_data", i), rf_wdata, lv[i].exp);
        end
        tick();

        // ALU only: two-edge latency, no bypass
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        tick();
        alu_valid = 1'b0;
        check("alu_lat_e0_we", rf_we, 0);
        tick();
        check("alu_lat_e1_we", rf_we, 1);
        check("alu_lat_e1_rd", rf_rd, 5);
        check("alu_lat_e1_data", rf_wdata, 64'h1234);
        tick();
        check("alu_lat_e2_we", rf_we, 0);
        check("alu_lat_e2_idle", wb_idle, 1);

        // Collision: load wins, ALU follows
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'hA7;
        tick();
        alu_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_funct3 = LD; lsu_addr_lo = 3'd0;
        lsu_rdata = 64'h9999_0000_9999;
        tick();
        lsu_valid = 1'b0;
        check("coll_load_we", rf_we, 1);
        check("coll_load_rd", rf_rd, 9);
        check("coll_load_data", rf_wdata, 64'h9999_0000_9999);
        tick();
        check("coll_alu_we", rf_we, 1);
        check("coll_alu_rd", rf_rd, 7);
        check("coll_alu_data", rf_wdata, 64'hA7);
        tick();
        check("coll_end_we", rf_we, 0);

        // Full: loads starve the FIFO, third push waits
        pushed = 0;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 64'h1111;
        for (int c = 0; c < 4; c++) begin
            lsu_valid = 1'b1; lsu_rd = 5'(20 + c); lsu_funct3 = LD;
            lsu_rdata = {$urandom, $urandom};
            tick();
            if (m_pushed) begin
                pushed++;
                alu_rd   = 5'(11 + pushed);
                alu_data = 64'h1111 * 64'(pushed + 1);
                if (pushed == 3) alu_valid = 1'b0;
            end
        end
        lsu_valid = 1'b0;
        check("full_pushes_during_loads", 64'(pushed), 2);
        check("full_ready_low", alu_ready, 0);
        for (int c = 0; c < 12; c++) begin
            tick();
            if (m_pushed) begin
                pushed++;
                if (pushed == 3) alu_valid = 1'b0;
            end
            if (rf_we && rf_rd >= 5'd11 && rf_rd <= 5'd13) got.push_back(int'(rf_rd));
        end
        alu_valid = 1'b0;
        check("full_total_pushes", 64'(pushed), 3);
        check("full_retire_count", 64'(got.size()), 3);
        for (int k = 0; k < got.size() && k < 3; k++)
            check($sformatf("full_order%0d", k), 64'(got[k]), 64'(11 + k));

        // rd = 0: consumed without a write
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFF;
        tick();
        alu_valid = 1'b0;
        check("rd0_buffered_idle", wb_idle, 0);
        tick();
        check("rd0_no_we", rf_we, 0);
        check("rd0_idle", wb_idle, 1);
        tick();
        check("rd0_no_we_after", rf_we, 0);

        // Reset mid-operation with two entries buffered
        lsu_valid = 1'b1; lsu_rd = 5'd25; lsu_funct3 = LD; lsu_rdata = 64'h55;
        alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 64'hE14;
        tick();
        alu_rd = 5'd15; alu_data = 64'hE15;
        tick();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        check("rst_pre_full", alu_ready, 0);
        check("rst_pre_we", rf_we, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_we", rf_we, 0);
        check("rst_async_ready", alu_ready, 1);
        check("rst_async_idle", wb_idle, 1);
        tick();
        rst_n = 1'b1;
        writes = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rf_we) writes++;
        end
        check("rst_no_stale_writes", 64'(writes), 0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            alu_valid   = ($urandom_range(0, 99) < 60);
            alu_rd      = 5'($urandom_range(0, 31));
            alu_data    = {$urandom, $urandom};
            lsu_valid   = ($urandom_range(0, 99) < 35);
            lsu_rd      = 5'($urandom_range(0, 31));
            lsu_funct3  = 3'($urandom_range(0, 7));
            lsu_addr_lo = 3'($urandom_range(0, 7));
            lsu_rdata   = {$urandom, $urandom};
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 5; c++) tick();
        check("final_idle", wb_idle, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
